pixel_tpg_engine: RTL and testbench

Parametrised, pipelined test-pattern generator for the VGA video path. It takes raw timing (`hcount`, `vcount`, `de`, syncs) from `vga_timing` and produces per-channel RGB of configurable depth, with syncs delayed to match. It supports eight pattern modes with frame-synchronous mode switching, per-frame horizontal scrolling and a frame counter. It replaces the fixed 3-bit, 4-mode generator in the pixel path.

---
 rtl/pixel_tpg_engine.sv | 245 ++++++++++++++++++++++++
 tb/tb_pixel_tpg_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_tpg_engine.sv
// Pipelined VGA test-pattern generator: eight pattern modes with frame-synchronous
// mode switching, per-frame horizontal scroll and a completed-frame counter.
module pixel_tpg_engine #(
   parameter int CW          = 4,
   parameter int CNT_W       = 10,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int GRID_LOG2   = 5,
   parameter int CHK_LOG2    = 5,
   parameter int CELL_W_LOG2 = 3,
   parameter int CELL_H_LOG2 = 4,
   parameter int GRAD_SHIFT  = 4
) (
   input  logic              clk_pix,
   input  logic              resetn,
   input  logic [CNT_W-1:0]  hcount,
   input  logic [CNT_W-1:0]  vcount,
   input  logic              de,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic [2:0]        mode_req,
   input  logic              scroll_en,
   input  logic [3:0]        scroll_step,
   input  logic [3*CW-1:0]   solid_rgb,
   output logic [CW-1:0]     rgb_r,
   output logic [CW-1:0]     rgb_g,
   output logic [CW-1:0]     rgb_b,
   output logic              de_out,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic [2:0]        mode_active,
   output logic [15:0]       frame_cnt
);

   localparam logic [CNT_W-1:0] BAR_PITCH = CNT_W'(H_ACTIVE / 8);
   localparam logic [CNT_W-1:0] BAR_LAST  = CNT_W'(7);
   localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] V_TICK    = CNT_W'(V_ACTIVE);
   localparam logic [CW-1:0]    MAX       = {CW{1'b1}};
   localparam logic [CW-1:0]    ZERO      = {CW{1'b0}};

   // Only the low bits of hx feed any pattern, so the scrolled coordinate is kept that narrow.
   localparam int HX_A = (GRID_LOG2 > CHK_LOG2 + 1) ? GRID_LOG2 : CHK_LOG2 + 1;
   localparam int HX_W = (HX_A > GRAD_SHIFT + CW) ? HX_A : GRAD_SHIFT + CW;

   localparam logic [2:0] MODE_BARS    = 3'd0;
   localparam logic [2:0] MODE_GRID    = 3'd1;
   localparam logic [2:0] MODE_CHECKER = 3'd2;
   localparam logic [2:0] MODE_CELL    = 3'd3;
   localparam logic [2:0] MODE_GRAD    = 3'd4;
   localparam logic [2:0] MODE_SOLID   = 3'd5;
   localparam logic [2:0] MODE_FLICKER = 3'd6;
   localparam logic [2:0] MODE_BLACK   = 3'd7;

   logic              tick_s;
   logic [2:0]        mode_eff_s;
   logic [15:0]       fcnt_eff_s;
   logic [CNT_W-1:0]  scroll_eff_s;
   logic [CNT_W-1:0]  scroll_off_r;
   logic [HX_W-1:0]   hx_s;
   logic [CNT_W-1:0]  bar_full_s;
   logic [2:0]        bar_s;
   logic              grid_s;
   logic              chk_s;
   logic              cell_s;

   logic [2:0]        bar_r;
   logic              grid_r;
   logic              chk_r;
   logic              cell_r;
   logic [CW-1:0]     grad_r;
   logic [2:0]        mode_r;
   logic              flick_white_r;
   logic [3*CW-1:0]   solid_r;
   logic              de_s1_r;
   logic              hs_s1_r;
   logic              vs_s1_r;

   logic [CW-1:0]     pix_r_s;
   logic [CW-1:0]     pix_g_s;
   logic [CW-1:0]     pix_b_s;

   assign tick_s = (de == 1'b0) && (hcount == {CNT_W{1'b0}}) && (vcount == V_TICK);

   // Frame-tick control: values seen by the tick pixel and loaded into the control registers.
   always_comb begin
      mode_eff_s   = mode_active;
      fcnt_eff_s   = frame_cnt;
      scroll_eff_s = scroll_off_r;
      if (tick_s) begin
         mode_eff_s = mode_req;
         fcnt_eff_s = frame_cnt + 16'd1;
         if (scroll_en) begin
            scroll_eff_s = scroll_off_r + CNT_W'(scroll_step);
         end else begin
            scroll_eff_s = scroll_off_r;
         end
      end else begin
         mode_eff_s   = mode_active;
         fcnt_eff_s   = frame_cnt;
         scroll_eff_s = scroll_off_r;
      end
   end

   // Stage-1 pattern geometry: scrolled x, bar index and per-mode hit flags.
   always_comb begin
      hx_s       = hcount[HX_W-1:0] + scroll_eff_s[HX_W-1:0];
      bar_full_s = hcount / BAR_PITCH;
      if (bar_full_s > BAR_LAST) begin
         bar_s = 3'd7;
      end else begin
         bar_s = bar_full_s[2:0];
      end
      grid_s = (hx_s[GRID_LOG2-1:0] == {GRID_LOG2{1'b0}}) ||
               (vcount[GRID_LOG2-1:0] == {GRID_LOG2{1'b0}}) ||
               (hcount == H_LAST) || (vcount == V_LAST);
      chk_s  = hx_s[CHK_LOG2] ^ vcount[CHK_LOG2];
      cell_s = (hcount[CELL_W_LOG2-1:0] == {CELL_W_LOG2{1'b0}}) ||
               (vcount[CELL_H_LOG2-1:0] == {CELL_H_LOG2{1'b0}});
   end

   // Control registers: mode, frame counter and scroll offset advance on the frame tick.
   always_ff @(posedge clk_pix or negedge resetn) begin
      if (!resetn) begin
         mode_active  <= 3'd0;
         frame_cnt    <= 16'd0;
         scroll_off_r <= {CNT_W{1'b0}};
      end else begin
         mode_active  <= mode_eff_s;
         frame_cnt    <= fcnt_eff_s;
         scroll_off_r <= scroll_eff_s;
      end
   end

   // Stage-1 pipeline registers.
   always_ff @(posedge clk_pix or negedge resetn) begin
      if (!resetn) begin
         bar_r         <= 3'd0;
         grid_r        <= 1'b0;
         chk_r         <= 1'b0;
         cell_r        <= 1'b0;
         grad_r        <= {CW{1'b0}};
         mode_r        <= 3'd0;
         flick_white_r <= 1'b0;
         solid_r       <= {(3*CW){1'b0}};
         de_s1_r       <= 1'b0;
         hs_s1_r       <= 1'b0;
         vs_s1_r       <= 1'b0;
      end else begin
         bar_r         <= bar_s;
         grid_r        <= grid_s;
         chk_r         <= chk_s;
         cell_r        <= cell_s;
         grad_r        <= hx_s[GRAD_SHIFT+CW-1:GRAD_SHIFT];
         mode_r        <= mode_eff_s;
         flick_white_r <= ~fcnt_eff_s[0];
         solid_r       <= solid_rgb;
         de_s1_r       <= de;
         hs_s1_r       <= hsync_in;
         vs_s1_r       <= vsync_in;
      end
   end

   // Stage-2 colour selection; blanking forces black regardless of mode.
   always_comb begin
      pix_r_s = ZERO;
      pix_g_s = ZERO;
      pix_b_s = ZERO;
      if (de_s1_r) begin
         case (mode_r)
            // Bar order white..black maps to R=~b1, G=~b2, B=~b0.
            MODE_BARS: begin
               pix_r_s = {CW{~bar_r[1]}};
               pix_g_s = {CW{~bar_r[2]}};
               pix_b_s = {CW{~bar_r[0]}};
            end
            MODE_GRID: begin
               pix_r_s = {CW{grid_r}};
               pix_g_s = {CW{grid_r}};
               pix_b_s = {CW{grid_r}};
            end
            MODE_CHECKER: begin
               pix_r_s = {CW{chk_r}};
               pix_g_s = {CW{chk_r}};
               pix_b_s = {CW{chk_r}};
            end
            MODE_CELL: begin
               pix_r_s = {CW{cell_r}};
               pix_g_s = ZERO;
               pix_b_s = ZERO;
            end
            MODE_GRAD: begin
               pix_r_s = grad_r;
               pix_g_s = grad_r;
               pix_b_s = grad_r;
            end
            MODE_SOLID: begin
               pix_r_s = solid_r[3*CW-1:2*CW];
               pix_g_s = solid_r[2*CW-1:CW];
               pix_b_s = solid_r[CW-1:0];
            end
            MODE_FLICKER: begin
               pix_r_s = {CW{flick_white_r}};
               pix_g_s = {CW{flick_white_r}};
               pix_b_s = {CW{flick_white_r}};
            end
            MODE_BLACK: begin
               pix_r_s = ZERO;
               pix_g_s = ZERO;
               pix_b_s = ZERO;
            end
            default: begin
               pix_r_s = ZERO;
               pix_g_s = ZERO;
               pix_b_s = ZERO;
            end
         endcase
      end else begin
         pix_r_s = ZERO;
         pix_g_s = ZERO;
         pix_b_s = ZERO;
      end
   end

   // Stage-2 output registers.
   always_ff @(posedge clk_pix or negedge resetn) begin
      if (!resetn) begin
         rgb_r     <= {CW{1'b0}};
         rgb_g     <= {CW{1'b0}};
         rgb_b     <= {CW{1'b0}};
         de_out    <= 1'b0;
         hsync_out <= 1'b0;
         vsync_out <= 1'b0;
      end else begin
         rgb_r     <= pix_r_s;
         rgb_g     <= pix_g_s;
         rgb_b     <= pix_b_s;
         de_out    <= de_s1_r;
         hsync_out <= hs_s1_r;
         vsync_out <= vs_s1_r;
      end
   end

endmodule

// File: tb/tb_pixel_tpg_engine.sv
// Directed self-checking bench for pixel_tpg_engine with default parameters
// (CW=4, 640x480, 10-bit counters); expected values are hand-computed.
module tb_pixel_tpg_engine;

   logic        clk_pix = 1'b0;
   logic        resetn;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic        de;
   logic        hsync_in;
   logic        vsync_in;
   logic [2:0]  mode_req;
   logic        scroll_en;
   logic [3:0]  scroll_step;
   logic [11:0] solid_rgb;
   logic [3:0]  rgb_r;
   logic [3:0]  rgb_g;
   logic [3:0]  rgb_b;
   logic        de_out;
   logic        hsync_out;
   logic        vsync_out;
   logic [2:0]  mode_active;
   logic [15:0] frame_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   pixel_tpg_engine dut (
      .clk_pix     (clk_pix),
      .resetn      (resetn),
      .hcount      (hcount),
      .vcount      (vcount),
      .de          (de),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .mode_req    (mode_req),
      .scroll_en   (scroll_en),
      .scroll_step (scroll_step),
      .solid_rgb   (solid_rgb),
      .rgb_r       (rgb_r),
      .rgb_g       (rgb_g),
      .rgb_b       (rgb_b),
      .de_out      (de_out),
      .hsync_out   (hsync_out),
      .vsync_out   (vsync_out),
      .mode_active (mode_active),
      .frame_cnt   (frame_cnt)
   );

   always #5 clk_pix = ~clk_pix;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_pix);
      #1;
   endtask

   // Present one pixel and wait the two-cycle pipeline latency.
   task automatic pixel(input logic [9:0] h, input logic [9:0] v, input logic d);
      hcount = h;
      vcount = v;
      de     = d;
      step();
      step();
   endtask

   // One frame tick followed by an idle blanking sample.
   task automatic tick();
      hcount = 10'd0;
      vcount = 10'd480;
      de     = 1'b0;
      step();
      hcount = 10'd700;
      vcount = 10'd490;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      step();
   endtask

   initial begin
      resetn      = 1'b0;
      hcount      = 10'd0;
      vcount      = 10'd0;
      de          = 1'b0;
      hsync_in    = 1'b0;
      vsync_in    = 1'b0;
      mode_req    = 3'd0;
      scroll_en   = 1'b0;
      scroll_step = 4'd0;
      solid_rgb   = 12'h5A3;
      step();
      step();
      check_eq("reset_rgb", {20'd0, rgb_r, rgb_g, rgb_b}, 32'h0);
      check_eq("reset_de_out", {31'd0, de_out}, 32'h0);
      check_eq("reset_mode", {29'd0, mode_active}, 32'h0);
      check_eq("reset_fcnt", {16'd0, frame_cnt}, 32'h0);
      resetn = 1'b1;
      step();

      // Colour bars at vcount=10.
      pixel(10'd0, 10'd10, 1'b1);
      check_eq("bar_white", {20'd0, rgb_r, rgb_g, rgb_b}, 32'hFFF);
      check_eq("bar_de_out", {31'd0, de_out}, 32'h1);
      pixel(10'd80, 10'd10, 1'b1);
      check_eq("bar_yellow", {20'd0, rgb_r, rgb_g, rgb_b}, 32'hFF0);
      pixel(10'd160, 10'd10, 1'b1);
      check_eq("bar_cyan", {20'd0, rgb_r, rgb_g, rgb_b}, 32'h0FF);
      pixel(10'd400, 10'd10, 1'b1);
      check_eq("bar_red", {20'd0, rgb_r, rgb_g, rgb_b}, 32'hF00);
      pixel(10'd639, 10'd10, 1'b1);
      check_eq("bar_black", {20'd0, rgb_r, rgb_g, rgb_b}, 32'h000);
      pixel(10'd0, 10'd10, 1'b0);
      check_eq("bar_blank", {20'd0, rgb_r, rgb_g, rgb_b}, 32'h000);
      check_eq("blank_de_out", {31'd0, de_out}, 32'h0);

      // hsync latency: visible only after the second edge.
      hsync_in = 1'b1;
      step();
      check_eq("hsync_lat1", {31'd0, hsync_out}, 32'h0);
      step();
      check_eq("hsync_lat2", {31'd0, hsync_out}, 32'h1);
      hsync_in = 1'b0;
      vsync_in = 1'b1;
      step();
      step();
      check_eq("hsync_drop", {31'd0, hsync_out}, 32'h0);
      check_eq("vsync_lat2", {31'd0, vsync_out}, 32'h1);
      vsync_in = 1'b0;

      // Mode request mid-frame is deferred to the tick.
      mode_req = 3'd2;
      pixel(10'd0, 10'd100, 1'b1);
      check_eq("switch_bars_cont", {20'd0, rgb_r, rgb_g, rgb_b}, 32'hFFF);
      check_eq("switch_mode_hold", {29'd0, mode_active}, 32'h0);
      tick();
      check_eq("switch_mode_new", {29'd0, mode_active}, 32'h2);
      check_eq("switch_fcnt", {16'd0, frame_cnt}, 32'h1);
      pixel(10'd0, 10'd0, 1'b1);
      check_eq("chk_0_0", {20'd0, rgb_r, rgb_g, rgb_b}, 32'h000);
      pixel(10'd32, 10'd0, 1'b1);
      check_eq("chk_32_0", {20'd0, rgb_r, rgb_g, rgb_b}, 32'hFFF);
      pixel(10'd32, 10'd32, 1'b1);
      check_eq("chk_32_32", {20'd0, rgb_r, rgb_g, rgb_b}, 32'h000);

      // Asynchronous reset mid-line in mode 0.
      mode_req = 3'd0;
      tick();
      hsync_in = 1'b1;
      pixel(10'd0, 10'd10, 1'b1);
      check_eq("pre_rst_rgb", {20'd0, rgb_r, rgb_g, rgb_b}, 32'hFFF);
      check_eq("pre_rst_fcnt", {16'd0, frame_cnt}, 32'h2);
      #3;
      resetn = 1'b0;
      #1;
      check_eq("async_rst_rgb", {20'd0, rgb_r, rgb_g, rgb_b}, 32'h000);
      check_eq("async_rst_sync", {29'd0, de_out, hsync_out, vsync_out}, 32'h0);
      check_eq("async_rst_fcnt", {16'd0, frame_cnt}, 32'h0);
      resetn = 1'b1;
      step();
      check_eq("refill_1", {19'd0, de_out, rgb_r, rgb_g, rgb_b}, 32'h0000);
      step();
      check_eq("refill_2", {19'd0, de_out, rgb_r, rgb_g, rgb_b}, 32'h1FFF);
      check_eq("refill_hsync", {31'd0, hsync_out}, 32'h1);
      hsync_in = 1'b0;

      // Scroll: three ticks of step 4 give offset 12.
      mode_req    = 3'd2;
      scroll_en   = 1'b1;
      scroll_step = 4'd4;
      tick();
      tick();
      tick();
      scroll_en = 1'b0;
      pixel(10'd20, 10'd0, 1'b1);
      check_eq("scroll_hx32", {20'd0, rgb_r, rgb_g, rgb_b}, 32'hFFF);
      pixel(10'd19, 10'd0, 1'b1);
      check_eq("scroll_hx31", {20'd0, rgb_r, rgb_g, rgb_b}, 32'h000);
      tick();
      pixel(10'd20, 10'd0, 1'b1);
      check_eq("scroll_hold", {20'd0, rgb_r, rgb_g, rgb_b}, 32'hFFF);

      // Scroll wrap: 68 x 15 = 1020, then +8 wraps to 4.
      do_reset();
      mode_req    = 3'd4;
      scroll_en   = 1'b1;
      scroll_step = 4'd15;
      for (int i = 0; i < 68; i++) tick();
      pixel(10'd0, 10'd0, 1'b1);
      check_eq("grad_hx1020", {20'd0, rgb_r, rgb_g, rgb_b}, 32'hFFF);
      pixel(10'd4, 10'd0, 1'b1);
      check_eq("grad_hx1024", {20'd0, rgb_r, rgb_g, rgb_b}, 32'h000);
      scroll_step = 4'd8;
      tick();
      scroll_en = 1'b0;
      pixel(10'd0, 10'd0, 1'b1);
      check_eq("wrap_hx4", {20'd0, rgb_r, rgb_g, rgb_b}, 32'h000);
      pixel(10'd12, 10'd0, 1'b1);
      check_eq("wrap_hx16", {20'd0, rgb_r, rgb_g, rgb_b}, 32'h111);

      // Grid, cell markers, solid and black with zero scroll.
      do_reset();
      mode_req = 3'd1;
      tick();
      pixel(10'd32, 10'd1, 1'b1);
      check_eq("grid_line", {20'd0, rgb_r, rgb_g, rgb_b}, 32'hFFF);
      pixel(10'd33, 10'd1, 1'b1);
      check_eq("grid_off", {20'd0, rgb_r, rgb_g, rgb_b}, 32'h000);
      pixel(10'd639, 10'd1, 1'b1);
      check_eq("grid_right", {20'd0, rgb_r, rgb_g, rgb_b}, 32'hFFF);
      pixel(10'd33, 10'd479, 1'b1);
      check_eq("grid_bottom", {20'd0, rgb_r, rgb_g, rgb_b}, 32'hFFF);
      mode_req = 3'd3;
      tick();
      pixel(10'd8, 10'd1, 1'b1);
      check_eq("cell_col", {20'd0, rgb_r, rgb_g, rgb_b}, 32'hF00);
      pixel(10'd9, 10'd1, 1'b1);
      check_eq("cell_off", {20'd0, rgb_r, rgb_g, rgb_b}, 32'h000);
      pixel(10'd9, 10'd16, 1'b1);
      check_eq("cell_row", {20'd0, rgb_r, rgb_g, rgb_b}, 32'hF00);
      mode_req = 3'd5;
      tick();
      pixel(10'd100, 10'd100, 1'b1);
      check_eq("solid", {20'd0, rgb_r, rgb_g, rgb_b}, 32'h5A3);
      mode_req = 3'd7;
      tick();
      pixel(10'd100, 10'd100, 1'b1);
      check_eq("mode7_black", {20'd0, rgb_r, rgb_g, rgb_b}, 32'h000);
      check_eq("mode7_active", {29'd0, mode_active}, 32'h7);

      // Flicker and frame counter wrap.
      do_reset();
      mode_req = 3'd6;
      tick();
      pixel(10'd5, 10'd5, 1'b1);
      check_eq("flick_odd", {20'd0, rgb_r, rgb_g, rgb_b}, 32'h000);
      tick();
      pixel(10'd5, 10'd5, 1'b1);
      check_eq("flick_even", {20'd0, rgb_r, rgb_g, rgb_b}, 32'hFFF);
      hcount = 10'd0;
      vcount = 10'd480;
      de     = 1'b0;
      repeat (65533) step();
      check_eq("fcnt_max", {16'd0, frame_cnt}, 32'hFFFF);
      pixel(10'd5, 10'd5, 1'b1);
      check_eq("flick_max", {20'd0, rgb_r, rgb_g, rgb_b}, 32'h000);
      tick();
      check_eq("fcnt_wrap", {16'd0, frame_cnt}, 32'h0);
      pixel(10'd5, 10'd5, 1'b1);
      check_eq("flick_wrap", {20'd0, rgb_r, rgb_g, rgb_b}, 32'hFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
